imm_extend_pipe: RTL

Pipelined, parametrised immediate-field extractor and extender for the SPU decode path. It accepts a 32-bit instruction word with a format select, extracts the I7/I10/I16/I18/I8 immediate field, and sign- or zero-extends it to a full register width. It can also replicate the extended value across every slot of the register. Two registered stages with valid/ready backpressure sit between instruction decode and the operand mux, and replace the purely combinational immediate select.

---
 rtl/imm_extend_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage immediate-field extractor/extender for the SPU decode path.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready + in_instr/in_sel/in_zext/in_repl
// input beat; out_valid/out_ready + out_data/out_err result beat (out_err = illegal in_sel).
// Latency: result visible two cycles after the input is presented; full throughput.
// Backpressure: S2 holds while out_valid && !out_ready, S1 holds when full behind it.
module imm_extend_pipe #(
  parameter int INSTR_W = 32,   // SPU encodings are fixed at 32 bits
  parameter int OUT_W   = 128,  // multiple of SLOT_W, at least 18
  parameter int SLOT_W  = 32    // 16, 32 or 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_sel,
  input  logic               in_zext,
  input  logic               in_repl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_err
);

  // Widest field (I18); every field is held right-justified in this many bits.
  localparam int FW = 18;

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  // S1 content moves forward whenever S2 is empty or S2 is draining this cycle.
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  // Gated with rst_n so nothing is accepted while the reset is being sampled.
  assign in_ready  = rst_n && (!s1_valid || !s2_valid || out_ready);
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------- S1 decode
  logic [FW-1:0] dec_field;
  logic [4:0]    dec_len;
  logic          dec_err;

  always_comb begin
    dec_field = '0;
    dec_len   = 5'd0;
    dec_err   = 1'b0;
    case (in_sel)
      3'b000: begin dec_field = {11'b0, in_instr[17:11]}; dec_len = 5'd7;  end
      3'b001: begin dec_field = {8'b0,  in_instr[17:8]};  dec_len = 5'd10; end
      3'b010: begin dec_field = {2'b0,  in_instr[24:9]};  dec_len = 5'd16; end
      3'b011: begin dec_field = in_instr[24:7];           dec_len = 5'd18; end
      3'b100: begin dec_field = {10'b0, in_instr[21:14]}; dec_len = 5'd8;  end
      default: dec_err = 1'b1;
    endcase
  end

  // Instruction bits outside every field position are intentionally ignored.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_instr[INSTR_W-1:25], in_instr[6:0]};

  // ---------------------------------------------------------------- S1 registers
  logic [FW-1:0] s1_field;
  logic [4:0]    s1_len;
  logic          s1_zext;
  logic          s1_repl;
  logic          s1_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_field <= '0;
      s1_len   <= 5'd0;
      s1_zext  <= 1'b0;
      s1_repl  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_field <= dec_field;
      s1_len   <= dec_len;
      s1_zext  <= in_zext;
      s1_repl  <= in_repl;
      s1_err   <= dec_err;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- S2 extend
  logic              sgn;
  logic              fill;
  logic [FW-1:0]     ext_field;
  logic [SLOT_W-1:0] slot_val;
  logic [OUT_W-1:0]  full_val;
  logic [OUT_W-1:0]  repl_val;
  logic [OUT_W-1:0]  res;

  always_comb begin
    // Sign bit is the field MSB at position len-1 (len is 0 only for illegal beats).
    sgn = 1'b0;
    for (int i = 0; i < FW; i++) begin
      if (i + 1 == int'(s1_len)) sgn = s1_field[i];
    end
    fill = sgn & ~s1_zext;

    for (int i = 0; i < FW; i++) begin
      ext_field[i] = (i < int'(s1_len)) ? s1_field[i] : fill;
    end

    // With SLOT_W = 16 an I18 field is simply truncated to its low 16 bits.
    slot_val = {SLOT_W{fill}};
    for (int i = 0; i < FW && i < SLOT_W; i++) begin
      slot_val[i] = ext_field[i];
    end

    full_val = {OUT_W{fill}};
    for (int i = 0; i < FW; i++) begin
      full_val[i] = ext_field[i];
    end

    for (int i = 0; i < OUT_W; i++) begin
      repl_val[i] = slot_val[i % SLOT_W];
    end

    if (s1_err)       res = '0;
    else if (s1_repl) res = repl_val;
    else              res = full_val;
  end

  // ---------------------------------------------------------------- S2 registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      out_data <= res;
      out_err  <= s1_err;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule
